// File: rtl/tagged_fifo_pkg.sv
// rtl/tagged_fifo_pkg.sv - level encoding and FSM state type for the tagged FIFO
package tagged_fifo_pkg;

    localparam logic LVL_L = 1'b0;
    localparam logic LVL_H = 1'b1;

    localparam int unsigned STATS_W = 8;

    typedef enum logic {
        RUN   = 1'b0,
        SCRUB = 1'b1
    } state_e;

endpackage

// File: rtl/tagged_fifo_mem.sv
// rtl/tagged_fifo_mem.sv - DEPTH x (WIDTH+1) storage, one write port with zero override, async read
module tagged_fifo_mem #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic          zero_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [WIDTH:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [WIDTH:0] rdata_o
);

    logic [WIDTH:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= zero_i ? '0 : wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tagged_fifo.sv
// rtl/tagged_fifo.sv - FWFT FIFO with per-entry security tag and scrub on clearance drop
// Optional scrub counter output enabled by TAGGED_FIFO_STATS_EN.
module tagged_fifo
    import tagged_fifo_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_tag,
    output logic             in_ready,
    input  logic             out_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_tag,
    input  logic             out_ready,
`ifdef TAGGED_FIFO_STATS_EN
    output logic [STATS_W-1:0] scrub_cnt,
`endif
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_e          state_q, state_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   scrub_idx_q, scrub_idx_d;
    logic [CW-1:0]   count_q, count_d;
    logic            clr_q;

    logic            run;
    logic            drop;
    logic            push;
    logic            pop;
    logic [WIDTH:0]  head;
    logic [AW-1:0]   scrub_addr;
    logic            mem_we;
    logic            mem_zero;
    logic [AW-1:0]   mem_waddr;

    assign run       = (state_q == RUN);
    assign drop      = clr_q && !out_clr;
    assign in_ready  = run && (count_q < CW'(DEPTH));
    assign out_valid = run && (count_q != '0) && ((head[WIDTH] == LVL_L) || (out_clr == LVL_H));
    assign out_data  = out_valid ? head[WIDTH-1:0] : '0;
    assign out_tag   = out_valid ? head[WIDTH] : LVL_L;
    assign busy      = (state_q == SCRUB);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // A drop mid-scrub restarts in the same cycle: that cycle already clears index 0.
    assign scrub_addr = drop ? '0 : scrub_idx_q;

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        scrub_idx_d = scrub_idx_q;
        mem_we      = 1'b0;
        mem_zero    = 1'b0;
        mem_waddr   = wr_ptr_q;
        unique case (state_q)
            RUN: begin
                if (drop) begin
                    state_d     = SCRUB;
                    rd_ptr_d    = '0;
                    wr_ptr_d    = '0;
                    count_d     = '0;
                    scrub_idx_d = '0;
                end else begin
                    if (push) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                    count_d = count_q + CW'(push) - CW'(pop);
                end
            end
            SCRUB: begin
                mem_we    = 1'b1;
                mem_zero  = 1'b1;
                mem_waddr = scrub_addr;
                if (scrub_addr == AW'(DEPTH - 1)) begin
                    state_d     = RUN;
                    scrub_idx_d = '0;
                end else begin
                    scrub_idx_d = scrub_addr + AW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= RUN;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            scrub_idx_q <= '0;
            clr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            scrub_idx_q <= scrub_idx_d;
            clr_q       <= out_clr;
        end
    end

    tagged_fifo_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .we_i    (mem_we),
        .zero_i  (mem_zero),
        .waddr_i (mem_waddr),
        .wdata_i ({in_tag, in_data}),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

`ifdef TAGGED_FIFO_STATS_EN
    logic [STATS_W-1:0] scrub_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            scrub_cnt_q <= '0;
        end else if (drop && (scrub_cnt_q != '1)) begin
            scrub_cnt_q <= scrub_cnt_q + STATS_W'(1);
        end
    end

    assign scrub_cnt = scrub_cnt_q;
`endif

endmodule

// File: tb/tb_tagged_fifo.sv
// tb/tb_tagged_fifo.sv - table vectors, corner sequences and random run against a queue model
module tb_tagged_fifo;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_tag;
    logic             in_ready;
    logic             out_clr;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_tag;
    logic             out_ready;
    logic             busy;
`ifdef TAGGED_FIFO_STATS_EN
    logic [7:0]       scrub_cnt;
`endif

    tagged_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .in_ready  (in_ready),
        .out_clr   (out_clr),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_ready (out_ready),
`ifdef TAGGED_FIFO_STATS_EN
        .scrub_cnt (scrub_cnt),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [3:0] id;
        logic       it;
        logic       clr;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [3:0] e_od;
        logic       e_ot;
        logic       e_busy;
        int         e_cnt;
    } vec_t;

    vec_t tbl[$];

    typedef struct packed {
        logic       tag;
        logic [3:0] data;
    } ent_t;

    ent_t mq[$];
    int   m_left;
    logic m_clrp;
    int   m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [3:0] d, input logic t,
                         input logic c, input logic o);
        reset = r; in_valid = v; in_data = d; in_tag = t; out_clr = c; out_ready = o;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    function automatic vec_t mk(input logic r, v, input logic [3:0] d, input logic t, c, o,
                                input logic eir, eov, input logic [3:0] eod, input logic eot, eb,
                                input int ec);
        vec_t x;
        x.rst = r; x.iv = v; x.id = d; x.it = t; x.clr = c; x.ordy = o;
        x.e_ir = eir; x.e_ov = eov; x.e_od = eod; x.e_ot = eot; x.e_busy = eb; x.e_cnt = ec;
        return x;
    endfunction

    // Counts busy cycles from the current cycle; bit k of pat is out_clr in cycle k.
    task automatic count_busy(input logic [15:0] pat, output int nb);
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b0;
            out_clr  = (k < 16) ? pat[k] : 1'b0;
            #2;
            if (!busy) break;
            nb++;
            tick();
        end
    endtask

    initial begin
        int nb;
        logic e_ir, e_ov, e_busy, drop;
        logic [3:0] e_od;
        logic e_ot;

        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        tbl.push_back(mk(1,0,4'h0,0,0,0, 1,0,4'h0,0,0, 0));
        tbl.push_back(mk(1,1,4'h3,0,0,0, 1,0,4'h0,0,0, 0));
        tbl.push_back(mk(1,1,4'h5,0,0,0, 1,1,4'h3,0,0, 1));
        tbl.push_back(mk(1,1,4'h9,0,0,0, 1,1,4'h3,0,0, 2));
        tbl.push_back(mk(1,0,4'h0,0,0,1, 1,1,4'h3,0,0, 3));
        tbl.push_back(mk(1,0,4'h0,0,0,1, 1,1,4'h5,0,0, 2));
        tbl.push_back(mk(1,0,4'h0,0,0,1, 1,1,4'h9,0,0, 1));
        tbl.push_back(mk(1,0,4'h0,0,0,0, 1,0,4'h0,0,0, 0));
        tbl.push_back(mk(1,1,4'hA,1,0,0, 1,0,4'h0,0,0, 0));
        tbl.push_back(mk(1,1,4'h6,0,0,1, 1,0,4'h0,0,0, 1));
        tbl.push_back(mk(1,0,4'h0,0,1,0, 1,1,4'hA,1,0, 2));
        tbl.push_back(mk(1,0,4'h0,0,1,1, 1,1,4'hA,1,0, 2));
        tbl.push_back(mk(1,0,4'h0,0,1,1, 1,1,4'h6,0,0, 1));
        tbl.push_back(mk(1,0,4'h0,0,1,0, 1,0,4'h0,0,0, 0));

        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].iv, tbl[i].id, tbl[i].it, tbl[i].clr, tbl[i].ordy);
            #2;
            chk($sformatf("tbl%0d.in_ready", i),  in_ready,    tbl[i].e_ir);
            chk($sformatf("tbl%0d.out_valid", i), out_valid,   tbl[i].e_ov);
            chk($sformatf("tbl%0d.out_data", i),  out_data,    tbl[i].e_od);
            chk($sformatf("tbl%0d.out_tag", i),   out_tag,     tbl[i].e_ot);
            chk($sformatf("tbl%0d.busy", i),      busy,        tbl[i].e_busy);
            chk($sformatf("tbl%0d.count", i),     dut.count_q, tbl[i].e_cnt);
            tick();
        end

        // full FIFO: push+pop with count 4 only pops
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 4'h7, 1'b0, 1'b0, 1'b1);
        #2;
        chk("full.in_ready", in_ready, 0);
        chk("full.count", dut.count_q, 4);
        chk("full.head", out_data, 1);
        tick();
        drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("full.count_after", dut.count_q, 3);
        chk("full.in_ready_after", in_ready, 1);
        chk("full.head_after", out_data, 2);
        tick();

        // clearance drop with 3 entries; the push in the drop cycle is discarded
        do_reset();
        drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, 4'hC, 1'b1, 1'b1, 1'b0); tick();
        drive(1'b1, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b1, 1'b1, 4'hE, 1'b1, 1'b1, 1'b0); tick();
        drive(1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
        #2;
        chk("drop.count_before", dut.count_q, 3);
        chk("drop.busy_before", busy, 0);
        tick();
        count_busy(16'h0000, nb);
        chk("drop.busy_cycles", nb, 4);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("drop.mem%0d", i), dut.u_mem.mem_q[i], 0);
        chk("drop.count", dut.count_q, 0);
        chk("drop.in_ready", in_ready, 1);
        chk("drop.out_valid", out_valid, 0);
`ifdef TAGGED_FIFO_STATS_EN
        chk("drop.scrub_cnt", scrub_cnt, 1);
`endif
        tick();

        // drop at scrub cycle 2, rise, drop again
        do_reset();
        drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        tick();
        out_clr = 1'b0;
        tick();
        count_busy(16'h0005, nb);
        chk("restart.busy_cycles", nb, 7);
`ifdef TAGGED_FIFO_STATS_EN
        chk("restart.scrub_cnt", scrub_cnt, 3);
`endif
        tick();

        // reset during scrub
        do_reset();
        drive(1'b1, 1'b1, 4'h8, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b1, 1'b1, 4'h4, 1'b1, 1'b1, 1'b0); tick();
        drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0); tick();
        #2;
        chk("rstscrub.busy_in", busy, 1);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #2;
        chk("rstscrub.busy", busy, 0);
        chk("rstscrub.count", dut.count_q, 0);
        chk("rstscrub.in_ready", in_ready, 1);
        chk("rstscrub.out_valid", out_valid, 0);
        tick();

        // randomized run against the queue model
        do_reset();
        mq.delete();
        m_left = 0;
        m_clrp = 1'b0;
        m_cnt  = 0;
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(99) != 0);
            in_valid  = 1'($urandom_range(1));
            in_data   = 4'($urandom_range(15));
            in_tag    = 1'($urandom_range(1));
            out_ready = 1'($urandom_range(1));
            if ($urandom_range(7) == 0) out_clr = ~out_clr;
            #2;
            e_busy = (m_left > 0);
            e_ir   = !e_busy && (mq.size() < DEPTH);
            e_ov   = !e_busy && (mq.size() > 0) && ((mq[0].tag == 1'b0) || out_clr);
            e_od   = e_ov ? mq[0].data : 4'h0;
            e_ot   = e_ov ? mq[0].tag : 1'b0;
            chk($sformatf("rnd%0d.in_ready", c),  in_ready,  e_ir);
            chk($sformatf("rnd%0d.out_valid", c), out_valid, e_ov);
            chk($sformatf("rnd%0d.out_data", c),  out_data,  e_od);
            chk($sformatf("rnd%0d.out_tag", c),   out_tag,   e_ot);
            chk($sformatf("rnd%0d.busy", c),      busy,      e_busy);
`ifdef TAGGED_FIFO_STATS_EN
            chk($sformatf("rnd%0d.scrub_cnt", c), scrub_cnt, m_cnt);
`endif
            if (!reset) begin
                mq.delete();
                m_left = 0;
                m_clrp = 1'b0;
                m_cnt  = 0;
            end else begin
                drop = m_clrp && !out_clr;
                if (drop) begin
                    mq.delete();
                    m_left = e_busy ? DEPTH - 1 : DEPTH;
                    if (m_cnt < 255) m_cnt++;
                end else if (e_busy) begin
                    m_left--;
                end else begin
                    if (e_ov && out_ready) void'(mq.pop_front());
                    if (in_valid && e_ir) mq.push_back({in_tag, in_data});
                end
                m_clrp = out_clr;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
